// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ARM-style ALU with internal NZCV register
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_wr,
  output logic [3:0]       out_flags,
  output logic [3:0]       nzcv
);
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [3:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s1_s_q;
  logic [WIDTH-1:0] result_q, result_d, x, y, lres;
  logic             wr_q;
  logic [3:0]       flags_q, nzcv_q, flags_d;
  logic             adv2, in_fire, exec, cin, arith, ovf, cmp, eff_s;
  logic [WIDTH:0]   sum;
  assign adv2       = !s2_valid_q | out_ready;
  assign in_ready   = !s1_valid_q | adv2;
  assign in_fire    = in_valid & in_ready & !flush;
  assign exec       = s1_valid_q & adv2 & !flush;
  assign s1_valid_d = !flush & (in_fire | (s1_valid_q & !adv2));
  assign s2_valid_d = !flush & (exec | (s2_valid_q & !out_ready));
  // Operand steering: every arithmetic op becomes x + y + cin
  always_comb begin
    x = s1_a_q;
    y = s1_b_q;
    cin = 1'b0;
    arith = 1'b1;
    case (s1_op_q)
      4'h2, 4'hA: begin y = ~s1_b_q; cin = 1'b1; end
      4'h3: begin x = s1_b_q; y = ~s1_a_q; cin = 1'b1; end
      4'h4, 4'hB: ;
      4'h5: cin = nzcv_q[1];
      4'h6: begin y = ~s1_b_q; cin = nzcv_q[1]; end
      4'h7: begin x = s1_b_q; y = ~s1_a_q; cin = nzcv_q[1]; end
      default: arith = 1'b0;
    endcase
  end
  assign sum  = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(cin);
  assign ovf  = (x[WIDTH-1] == y[WIDTH-1]) & (sum[WIDTH-1] != x[WIDTH-1]);
  assign lres = (s1_op_q == 4'h0 || s1_op_q == 4'h8) ? s1_a_q & s1_b_q :
                (s1_op_q == 4'h1 || s1_op_q == 4'h9) ? s1_a_q ^ s1_b_q :
                (s1_op_q == 4'hC) ? s1_a_q | s1_b_q :
                (s1_op_q == 4'hD) ? s1_b_q :
                (s1_op_q == 4'hE) ? s1_a_q & ~s1_b_q : ~s1_b_q;
  assign result_d = arith ? sum[WIDTH-1:0] : lres;
  assign flags_d  = {result_d[WIDTH-1], result_d == '0,
                     arith ? sum[WIDTH] : nzcv_q[1], arith ? ovf : nzcv_q[0]};
  assign cmp   = s1_op_q[3:2] == 2'b10;
  assign eff_s = s1_s_q | cmp;
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_op_q <= op;
      s1_a_q  <= a;
      s1_b_q  <= b;
      s1_s_q  <= s;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      wr_q       <= 1'b0;
      flags_q    <= '0;
      nzcv_q     <= FLAGS_RESET;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (exec) begin
        result_q <= result_d;
        wr_q     <= !cmp;
        flags_q  <= eff_s ? flags_d : nzcv_q;
        if (eff_s) nzcv_q <= flags_d;
      end
    end
  end
  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign out_wr    = wr_q;
  assign out_flags = flags_q;
  assign nzcv      = nzcv_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe against an arithmetic reference model
module tb_alu_pipe;
  typedef struct packed {logic [31:0] r; logic wr; logic [3:0] f;} exp_t;
  logic clk = 1'b0, reset, in_valid, in_ready, s, flush, out_valid, out_ready, out_wr;
  logic [3:0] op, out_flags, nzcv;
  logic [31:0] a, b, result;
  logic [3:0] m_nzcv;
  logic rnd_ready;
  exp_t sbq[$];
  int checks = 0, failures = 0;
  alu_pipe #(.WIDTH(32), .FLAGS_RESET(4'b0000)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .s(s), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_wr(out_wr), .out_flags(out_flags), .nzcv(nzcv));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  // Reference: signed/unsigned integer arithmetic, flags from range checks
  task automatic predict(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                         input logic xs, output exp_t e);
    longint ua = {32'h0, xa}, ub = {32'h0, xb};
    longint sa = $signed(xa), sb = $signed(xb);
    longint u = 0, sr = 0;
    bit c = m_nzcv[1], v = m_nzcv[0], arith = 1, sub = 0;
    logic [31:0] r;
    case (o)
      4'h0, 4'h8: begin r = xa & xb; arith = 0; end
      4'h1, 4'h9: begin r = xa ^ xb; arith = 0; end
      4'hC: begin r = xa | xb; arith = 0; end
      4'hD: begin r = xb; arith = 0; end
      4'hE: begin r = xa & ~xb; arith = 0; end
      4'hF: begin r = ~xb; arith = 0; end
      4'h4, 4'hB: begin u = ua + ub; sr = sa + sb; end
      4'h5: begin u = ua + ub + c; sr = sa + sb + c; end
      4'h2, 4'hA: begin u = ua - ub; sr = sa - sb; sub = 1; end
      4'h6: begin u = ua - ub - !c; sr = sa - sb - !c; sub = 1; end
      4'h3: begin u = ub - ua; sr = sb - sa; sub = 1; end
      default: begin u = ub - ua - !c; sr = sb - sa - !c; sub = 1; end
    endcase
    if (arith) begin
      r = u[31:0];
      c = sub ? (u >= 0) : u[32];
      v = sr != longint'($signed(r));
    end
    if (xs || o[3:2] == 2'b10) m_nzcv = {r[31], r == 0, c, v};
    e.r = r;
    e.wr = o[3:2] != 2'b10;
    e.f = m_nzcv;
  endtask
  // Monitor: every output transfer must match the oldest outstanding prediction
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output result=%h wr=%b flags=%b", result, out_wr, out_flags);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if ({result, out_wr, out_flags} !== e) begin
          failures++;
          $display("FAIL output got r=%h wr=%b f=%b exp r=%h wr=%b f=%b",
                   result, out_wr, out_flags, e.r, e.wr, e.f);
        end
      end
    end
  end
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      if (rnd_ready) out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                      input logic xs, input bit keep);
    int n = 0;
    logic fire;
    exp_t e;
    in_valid = 1'b1; op = o; a = xa; b = xb; s = xs;
    do begin
      if (rnd_ready) out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      fire = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!fire && n < 100);
    in_valid = 1'b0;
    if (!fire) chk("accept_timeout", 0, 1);
    else if (keep) begin
      predict(o, xa, xb, xs, e);
      sbq.push_back(e);
    end
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    reset = 1; in_valid = 0; flush = 0; out_ready = 1; rnd_ready = 0;
    op = 0; a = 0; b = 0; s = 0; m_nzcv = 4'b0000;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_nzcv", nzcv, 0);
    chk("rst_result", result, 0);
    send(4'h4, 32'h40000000, 32'h40000000, 1, 1);
    chk("lat_add_k", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_add_k1", out_valid, 1);
    chk("add_ovf_flags", out_flags, 4'b1001);
    idle(2);
    send(4'h4, 32'hFFFFFFFF, 32'h1, 1, 1);
    send(4'h5, 32'h0, 32'h0, 0, 1);
    idle(3);
    chk("adc_nzcv", nzcv, 4'b0110);
    send(4'hA, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 1);
    send(4'h6, 32'h0, 32'h2, 1, 1);
    idle(3);
    chk("sbc_nzcv", nzcv, 4'b1000);
    out_ready = 0;
    send(4'h0, 32'hA, 32'h2, 0, 1);
    send(4'h1, 32'hA, 32'h2, 0, 1);
    in_valid = 1; op = 4'hC; a = 32'hA; b = 32'h2; s = 0;
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1;
    send(4'hC, 32'hA, 32'h2, 0, 1);
    idle(4);
    chk("bp_drained", sbq.size(), 0);
    send(4'h2, 32'h0, 32'h2, 1, 0);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    idle(4);
    chk("flush_nzcv", nzcv, m_nzcv);
    in_valid = 1; op = 4'h4; a = 1; b = 1; s = 1; flush = 1;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    idle(4);
    chk("flush_in_nzcv", nzcv, m_nzcv);
    send(4'h4, 32'h1, 32'h1, 1, 1);
    chk("post_flush_k", out_valid, 0);
    @(posedge clk); #1;
    chk("post_flush_k1", out_valid, 1);
    chk("post_flush_res", result, 2);
    idle(2);
    out_ready = 0;
    send(4'h4, 32'h1, 32'h1, 1, 1);
    send(4'h2, 32'h1, 32'h5, 1, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    sbq.delete();
    m_nzcv = 4'b0000;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_nzcv", nzcv, 0);
    chk("mrst_result", result, 0);
    chk("mrst_wr_flags", {out_wr, out_flags}, 0);
    out_ready = 1;
    rnd_ready = 1;
    for (int i = 0; i < 400; i++) begin
      send(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 1)), 1);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    rnd_ready = 0;
    out_ready = 1;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) idle(1);
    idle(2);
    chk("final_drained", sbq.size(), 0);
    chk("final_nzcv", nzcv, m_nzcv);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the combinational ARM-style ALU.
- Sits between decode/operand fetch and writeback in the CPU datapath.
- Uses valid/ready handshakes on both sides.
- Holds the architectural NZCV register internally, so back-to-back flag-consuming ops (ADC/SBC/RSC) see the flags of every earlier op in program order.
- Tags compare/test ops so writeback suppresses the register write.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8).
- FLAGS_RESET, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  stage 1 can accept
- op  in  4  opcode: 0000 AND, 0001 EOR, 0010 SUB, 0011 RSB, 0100 ADD, 0101 ADC, 0110 SBC, 0111 RSC, 1000 TST, 1001 TEQ, 1010 CMP, 1011 CMN, 1100 ORR, 1101 MOV, 1110 BIC, 1111 MVN
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- s  in  1  update flags (forced 1 for TST/TEQ/CMP/CMN)
- flush  in  1  synchronous pipeline kill
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  ALU result
- out_wr  out  1  1 = writeback should write result; 0 for TST/TEQ/CMP/CMN
- out_flags  out  4  NZCV produced by this op (post-update value)
- nzcv  out  4  architectural flag register

Behaviour:
- Clocking/reset: one clock. Reset is synchronous and active-high on clk/reset.
- Reset values: s1/s2 valid=0, out_valid=0, result=0, out_wr=0, out_flags=0, nzcv=FLAGS_RESET. Reset dominates flush and all handshakes.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - adv2 = !s2_valid | out_ready.
  - in_ready = !s1_valid | adv2, combinational, no dependence on in_valid.
- Stage 1: on input transfer, register op/a/b/s. No arithmetic.
- Stage 2 (execute):
  - When s1_valid & adv2, compute from the S1 registers and current nzcv; load result/out_wr/out_flags and set s2_valid.
  - If s1_valid=0 and out_ready=1, s2_valid clears.
  - The output registers hold stable while out_valid & !out_ready.
- Latency and throughput:
  - Op accepted at edge k appears with out_valid=1 after edge k+1.
  - Throughput is 1 op/cycle with out_ready held high.
  - With out_ready low, at most 2 ops are held; in_ready falls only when both stages are full.
- Arithmetic (all at WIDTH+1 bits, modulo 2^WIDTH):
  - SUB = A+~B+1
  - RSB = B+~A+1
  - ADD = A+B
  - ADC = A+B+C
  - SBC = A+~B+C
  - RSC = B+~A+C
  - CMP as SUB; CMN as ADD.
  - C = bit WIDTH of the sum (borrow inverted, ARM convention).
  - V = operands' sign bits equal and result sign differs (effective operands after inversion).
- Logical ops:
  - AND, EOR, ORR, BIC = A&~B, MOV = B, MVN = ~B, TST = AND, TEQ = EOR.
  - C and V keep their old values.
- N and Z for all ops: N = result[WIDTH-1]; Z = (result==0).
- Flag update:
  - nzcv is updated on the same edge the op enters S2, iff effective s=1.
  - The next op in S1 then uses the updated C: correct ordering with no stall.
  - out_flags = nzcv after the op, or unchanged nzcv when s=0.
- Compare/test ops: result still driven, out_wr=0.
- Flush:
  - Clears s1_valid and s2_valid next edge; any in-flight op is discarded.
  - Flag updates already taken are kept; the S1 op being flushed must not update nzcv.
  - An input transfer on a flush cycle is dropped.
- Simultaneous events:
  - Output transfer and S1→S2 advance in the same cycle: S2 is replaced, no bubble.
  - Input transfer with S1 advance in the same cycle: S1 is replaced.
- Unknowns: no X on outputs after reset, for any input sequence.

Test Plan:
- Reset with WIDTH=32 -> out_valid=0, in_ready=1, nzcv=0000, result=0; same after reset asserted mid-stream with 2 ops in flight.
- ADD 0x40000000+0x40000000, s=1, accepted at edge k -> out_valid after edge k+1; result=0x80000000, NZCV=1001, out_wr=1.
- Back-to-back ADD 0xFFFFFFFF+1 s=1, then ADC 0+0 s=0 -> results 0x00000000 (NZCV=0110) then 0x00000001; nzcv stays 0110.
- CMP 0x7FFFFFFF,0x7FFFFFFF, then SBC A=0,B=2 s=1 -> CMP: out_wr=0, NZCV=0110. SBC: result 0xFFFFFFFE, NZCV=1000.
- out_ready=0; offer AND, EOR, ORR with A=0xA, B=0x2 -> in_ready=0 after 2 accepts. Release out_ready -> results 0x2, 0x8, 0xA in order, each exactly once, out_wr=1.
- SUB 0-2 s=1 in S1 with flush asserted -> no output ever; nzcv unchanged. Next ADD 1+1 -> result 2 with normal 2-cycle latency.
